// File: rtl/uart_pkg.sv
// Shared UART definitions: the state encoding used by both the transmitter and
// the receiver, and the default framing parameters.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int UART_RATE  = 16;
  localparam int UART_NBITS = 8;

endpackage

// File: rtl/uart_rx_os_if.sv
// Receive-side bus: the tick enable and serial line come in; the parallel word
// and its done/error strobes go out.
interface uart_rx_os_if #(parameter int NBITS = uart_pkg::UART_NBITS);

  logic             ticks;
  logic             Rx;
  logic [NBITS-1:0] Rx_data;
  logic             Rx_done;
  logic             Rx_err;

  modport master (output ticks, output Rx, input Rx_data, input Rx_done, input Rx_err);
  modport slave  (input ticks, input Rx, output Rx_data, output Rx_done, output Rx_err);

endinterface

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous Rx pin into the clock domain and flags a
// high-to-low transition as seen at tick rate.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic rx_i,
  output logic rx_s_o,
  output logic start_edge_o
);

  logic sync1_q;
  logic sync2_q;
  logic rx_prev_q;

  // Everything resets high so a reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      if (tick_i) begin
        rx_prev_q <= sync2_q;
      end
    end
  end

  assign rx_s_o       = sync2_q;
  assign start_edge_o = rx_prev_q & ~sync2_q;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling 8N1 receiver: finds the start bit centre, then samples each data
// bit and the stop bit at its centre, strobing done or framing error.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int RATE  = UART_RATE,
  parameter int NBITS = UART_NBITS
) (
  input  logic         clk,
  input  logic         rst,
  uart_rx_os_if.slave  bus
);

  localparam int CNT_W = $clog2(RATE);
  localparam int BIT_W = $clog2(NBITS + 1);

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(RATE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);

  uart_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [BIT_W-1:0] bit_q;
  logic [NBITS-1:0] shift_q;
  logic [NBITS-1:0] data_q;
  logic             done_q;
  logic             err_q;

  logic rx_s;
  logic start_edge;

  uart_rx_sync u_sync (
    .clk          (clk),
    .rst          (rst),
    .tick_i       (bus.ticks),
    .rx_i         (bus.Rx),
    .rx_s_o       (rx_s),
    .start_edge_o (start_edge)
  );

  // Strobes default low every clk so they last one clk, not one tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (bus.ticks) begin
        unique case (state_q)
          IDLE: begin
            if (start_edge) begin
              state_q <= START;
              cnt_q   <= '0;
            end
          end
          START: begin
            if (cnt_q == CNT_MID) begin
              if (!rx_s) begin
                state_q <= DATA;
                cnt_q   <= '0;
                bit_q   <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          DATA: begin
            if (cnt_q == CNT_LAST) begin
              shift_q <= {rx_s, shift_q[NBITS-1:1]};
              cnt_q   <= '0;
              bit_q   <= bit_q + BIT_W'(1);
              if (bit_q == BIT_LAST) begin
                state_q <= STOP;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          STOP: begin
            // Leaving at mid stop bit gives half a bit to catch a back-to-back start.
            if (cnt_q == CNT_LAST) begin
              if (rx_s) begin
                data_q <= shift_q;
                done_q <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
              state_q <= IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.Rx_data = data_q;
  assign bus.Rx_done = done_q;
  assign bus.Rx_err  = err_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: a behavioural 8N1 transmitter drives Rx
// and a scoreboard matches every done/error strobe against expected events.
module tb_uart_rx_os;

  localparam int BIT_CLK = 64;

  typedef struct {
    bit         err;
    logic [7:0] data;
  } ev_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  ev_t  sb[$];

  uart_rx_os_if #(.NBITS(8)) bus ();

  uart_rx_os #(.RATE(16), .NBITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-clk tick every 4 clk, driven away from the active edge.
  initial begin
    bus.ticks = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      bus.ticks = 1'b1;
      @(negedge clk);
      bus.ticks = 1'b0;
    end
  end

  // Any strobe, or a strobe lasting more than one clk, must match a queued event.
  always @(negedge clk) begin
    if (bus.Rx_done || bus.Rx_err) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("[TB] FAIL unexpected_pulse: done=%0b err=%0b data=%02h, required no pulse",
                 bus.Rx_done, bus.Rx_err, bus.Rx_data);
      end else begin
        ev_t e;
        e = sb.pop_front();
        if ({bus.Rx_done, bus.Rx_err} !== {~e.err, e.err}) begin
          n_bad++;
          $display("[TB] FAIL pulse_kind: done/err=%b, required %b",
                   {bus.Rx_done, bus.Rx_err}, {~e.err, e.err});
        end
        n_cmp++;
        if (bus.Rx_data !== e.data) begin
          n_bad++;
          $display("[TB] FAIL pulse_data: Rx_data=%02h, required %02h", bus.Rx_data, e.data);
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_ev(input bit err, input logic [7:0] data);
    ev_t e;
    e.err  = err;
    e.data = data;
    sb.push_back(e);
  endtask

  // Sends start, 8 data bits LSB first, then the stop level for one bit.
  // A non-negative abort_bit pulses reset mid-way through that data bit and abandons the frame.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int per, input int abort_bit);
    bus.Rx = 1'b0;
    wait_clk(per);
    for (int i = 0; i < 8; i++) begin
      bus.Rx = d[i];
      if (i == abort_bit) begin
        wait_clk(per / 2);
        rst = 1'b0;
        wait_clk(3);
        rst = 1'b1;
        bus.Rx = 1'b1;
        return;
      end
      wait_clk(per);
    end
    bus.Rx = stop;
    wait_clk(per);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL %s_drain: %0d events still pending, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst    = 1'b0;
    bus.Rx = 1'b1;
    wait_clk(5);
    n_cmp++;
    if (bus.Rx_data !== 8'h00) begin
      n_bad++;
      $display("[TB] FAIL reset_data: Rx_data=%02h, required 00", bus.Rx_data);
    end
    n_cmp++;
    if (bus.Rx_done !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_done: Rx_done=%b, required 0", bus.Rx_done);
    end
    n_cmp++;
    if (bus.Rx_err !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_err: Rx_err=%b, required 0", bus.Rx_err);
    end
    rst = 1'b1;
    wait_clk(2 * BIT_CLK);
  endtask

  task automatic test_single();
    push_ev(1'b0, 8'hA5);
    send_frame(8'hA5, 1'b1, BIT_CLK, -1);
    wait_drain("single");
    wait_clk(BIT_CLK);
    n_cmp++;
    if (bus.Rx_data !== 8'hA5) begin
      n_bad++;
      $display("[TB] FAIL single_hold: Rx_data=%02h, required A5", bus.Rx_data);
    end
  endtask

  task automatic test_glitch();
    bus.Rx = 1'b0;
    wait_clk(20);
    bus.Rx = 1'b1;
    wait_clk(3 * BIT_CLK);
    n_cmp++;
    if (bus.Rx_data !== 8'hA5) begin
      n_bad++;
      $display("[TB] FAIL glitch_hold: Rx_data=%02h, required A5", bus.Rx_data);
    end
  endtask

  task automatic test_framing();
    push_ev(1'b1, 8'hA5);
    send_frame(8'h3C, 1'b0, BIT_CLK, -1);
    wait_drain("framing_err");
    wait_clk(20 * BIT_CLK);
    bus.Rx = 1'b1;
    wait_clk(2 * BIT_CLK);
    n_cmp++;
    if (bus.Rx_data !== 8'hA5) begin
      n_bad++;
      $display("[TB] FAIL framing_hold: Rx_data=%02h, required A5", bus.Rx_data);
    end
    push_ev(1'b0, 8'h01);
    send_frame(8'h01, 1'b1, BIT_CLK, -1);
    wait_drain("framing_recover");
    wait_clk(BIT_CLK);
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    bytes[0] = 8'h00;
    bytes[1] = 8'hFF;
    bytes[2] = 8'h55;
    for (int i = 0; i < 3; i++) push_ev(1'b0, bytes[i]);
    for (int i = 0; i < 3; i++) send_frame(bytes[i], 1'b1, BIT_CLK, -1);
    wait_drain("back_to_back");
    wait_clk(BIT_CLK);
  endtask

  task automatic test_reset_abort();
    send_frame(8'h96, 1'b1, BIT_CLK, 4);
    wait_clk(1);
    n_cmp++;
    if (bus.Rx_data !== 8'h00) begin
      n_bad++;
      $display("[TB] FAIL abort_data: Rx_data=%02h, required 00", bus.Rx_data);
    end
    wait_clk(12 * BIT_CLK);
    push_ev(1'b0, 8'h69);
    send_frame(8'h69, 1'b1, BIT_CLK, -1);
    wait_drain("abort_recover");
    wait_clk(BIT_CLK);
  endtask

  task automatic test_tolerance();
    int per [2];
    per[0] = 62;
    per[1] = 66;
    for (int i = 0; i < 2; i++) begin
      push_ev(1'b0, 8'hC3);
      send_frame(8'hC3, 1'b1, per[i], -1);
      wait_drain(i == 0 ? "fast_baud" : "slow_baud");
      wait_clk(2 * BIT_CLK);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst    = 1'b0;
    bus.Rx = 1'b1;
    test_reset();
    test_single();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_abort();
    test_tolerance();
    wait_clk(BIT_CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- 16x-oversampling UART receiver. It is the receive-side counterpart of the team's UART transmitter.
- It recovers 8N1 frames (LSB first) from the serial line Rx, using the shared baud-tick enable.
- Each received byte is presented as a parallel word with a one-clock done strobe. A bad stop bit is flagged as a framing error.
- It sits between the board Rx pin and the host-side byte consumer.

Parameters:
- RATE, 16, tick enables per bit period. Must be even and ≥4.
- NBITS, 8, data bits per frame. Range 5–8.

Ports:
- clk  in  1  system clock. All state changes happen on posedge clk.
- rst  in  1  asynchronous, active-low reset.
- ticks  in  1  one-clk-wide enable pulse at RATE × baud. FSM and counters advance only on clk edges where ticks=1.
- Rx  in  1  asynchronous serial input. Idle level is high.
- Rx_data  out  NBITS  last correctly framed byte. Holds its value until the next good frame.
- Rx_done  out  1  one-clk pulse: Rx_data has just been updated.
- Rx_err  out  1  one-clk pulse: stop bit sampled low. Rx_data is not updated.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, bit_cnt=0, shift=0.
  - Rx_data=0, Rx_done=0, Rx_err=0.
  - Synchronizer flops and the previous-sample flop reset to 1.
- Input path:
  - Rx passes through a 2-flop synchronizer clocked every clk, giving rx_s.
  - rx_prev captures rx_s on tick edges.
  - A start is a falling edge seen on a tick: rx_prev=1 and rx_s=0.
- Rx_done and Rx_err are cleared on every clk where they are not being set. Each pulse is exactly 1 clk wide, not 1 tick wide.
- FSM states: IDLE, START, DATA, STOP. Every transition below happens on a tick edge.
- IDLE:
  - On a falling edge: go to START, counter=0.
  - Otherwise stay in IDLE.
  - A line held low (break, or the tail after an error) never retriggers. A new frame needs rx_s high for at least one tick first.
- START:
  - counter increments each tick.
  - At counter=RATE/2−1 (the mid start bit):
    - rx_s=0: go to DATA, counter=0, bit_cnt=0.
    - rx_s=1 (glitch): return to IDLE with no outputs asserted.
- DATA:
  - counter increments each tick.
  - At counter=RATE−1, sample rx_s: shift={rx_s, shift[NBITS−1:1]} (LSB first, shifted in at the MSB), counter=0, bit_cnt++.
  - After the NBITS-th sample, go to STOP.
- STOP:
  - At counter=RATE−1, sample rx_s:
    - rx_s=1: Rx_data←shift and Rx_done=1 on the same edge.
    - rx_s=0: Rx_err=1, Rx_data unchanged.
  - Either way, go to IDLE on that edge.
- Latency: Rx_done rises on the clk edge of the tick at mid stop bit. That is about NBITS+1.5 bit periods after the start falling edge, plus 2 clk of synchronizer delay.
- Back-to-back frames: returning to IDLE at mid stop bit leaves half a bit of margin to catch the next start edge. Zero idle time between frames is supported.
- Tolerance: sampling at bit centres tolerates ≥±3% baud mismatch at RATE=16.
- Reset asserted mid-frame aborts the frame with no Rx_done or Rx_err. After release, the next frame is received normally.
- counter width is clog2(RATE). bit_cnt width is clog2(NBITS+1). Neither may wrap in normal operation.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding (IDLE/START/DATA/STOP, 2 bits), shared with the transmitter;
  - defaults UART_RATE=16 and UART_NBITS=8.
- Sub-module uart_rx_sync holds the 2-flop synchronizer plus rx_prev and the falling-edge detect. Its outputs are rx_s and start_edge.
- FSM, counters and shift register stay in uart_rx_os.

Test Plan:
- Common setup: RATE=16, ticks every 4 clk, Rx driven by a behavioural 8N1 model.
- Send 0xA5 → exactly one Rx_done pulse of 1 clk, Rx_data=0xA5, Rx_err never asserted.
- Low glitch of 5 ticks on an idle line → returns to IDLE; no Rx_done or Rx_err; Rx_data holds its prior value.
- Send 0x3C with stop bit forced 0, line held low for 20 bit periods, then high, then send 0x01:
  - a single Rx_err pulse, Rx_data stays 0xA5, no retrigger during the low period;
  - then Rx_done with Rx_data=0x01.
- Back-to-back 0x00, 0xFF, 0x55 with no idle gap → three Rx_done pulses with Rx_data 0x00, 0xFF, 0x55 in order.
- Assert rst for 3 clk during DATA bit 4 of 0x96, then send 0x69 → no pulse for the aborted frame; Rx_data=0 after reset; then Rx_done with 0x69.
- Transmitter baud at +3% and −3% sending 0xC3 → Rx_data=0xC3, no Rx_err.
